// File: rtl/bcd_decoder4_10.sv
// bcd_decoder4_10: 4-to-10 BCD decoder on a valid/ready stream, 2-entry output buffer.
// Define SEG7_EN to add the seg output (7-segment pattern travelling with each word).
module bcd_decoder4_10 #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode_sel,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       din,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [9:0]       dout,
   output logic             out_err,
   input  logic             err_clr,
   output logic [CNT_W-1:0] err_cnt
`ifdef SEG7_EN
   ,
   output logic [6:0]       seg
`endif
);

`ifdef SEG7_EN
   localparam int WW = 18;
`else
   localparam int WW = 11;
`endif

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t            state_q, state_d;
   logic [WW-1:0]     out_q, out_d;
   logic [WW-1:0]     skid_q, skid_d;
   logic [WW-1:0]     word_new;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              acc, pop, inv_acc;

   // Word layout: {seg (optional), err, code}
   function automatic logic [WW-1:0] decode(input logic [3:0] d,
                                            input logic pri);
      logic       bad;
      logic [9:0] oh, th, code;
      bad  = (d > 4'd9);
      oh   = 10'd1 << d;
      th   = (10'd1 << (5'(d) + 5'd1)) - 10'd1;
      code = bad ? 10'd0 : (pri ? th : oh);
`ifdef SEG7_EN
      begin
         logic [6:0] s;
         case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
         endcase
         return {s, bad, code};
      end
`else
      return {bad, code};
`endif
   endfunction

   assign in_ready  = en & (state_q != TWO);
   assign out_valid = (state_q != EMPTY);
   assign acc       = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign word_new  = decode(din, mode_sel);
   assign inv_acc   = acc & word_new[10];

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (acc) begin
               out_d   = word_new;
               state_d = ONE;
            end
         end
         ONE: begin
            if (acc && pop) begin
               out_d = word_new;
            end else if (acc) begin
               skid_d  = word_new;
               state_d = TWO;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               out_d   = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Clear wins over increment, but a same-cycle invalid still counts once
   always_comb begin
      cnt_d = cnt_q;
      if (err_clr) begin
         cnt_d = inv_acc ? CNT_W'(1) : '0;
      end else if (inv_acc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         out_q   <= '0;
         skid_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout    = out_q[9:0];
   assign out_err = out_q[10];
   assign err_cnt = cnt_q;
`ifdef SEG7_EN
   assign seg     = out_q[17:11];
`endif

endmodule

// File: tb/tb_bcd_decoder4_10.sv
// tb_bcd_decoder4_10: queue-based reference model plus directed literal checks
// for bcd_decoder4_10 (two instances: CNT_W=8 and CNT_W=2).
module tb_bcd_decoder4_10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0, mode_sel = 1'b0, in_valid = 1'b0;
   logic       out_ready = 1'b0, err_clr = 1'b0;
   logic [3:0] din = 4'd0;

   logic       in_ready, out_valid, out_err;
   logic [9:0] dout;
   logic [7:0] err_cnt;
   logic       in_ready2, out_valid2, out_err2;
   logic [9:0] dout2;
   logic [1:0] err_cnt2;
`ifdef SEG7_EN
   logic [6:0] seg, seg2;
`endif

   int nchk = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   bcd_decoder4_10 #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst), .en(en), .mode_sel(mode_sel),
      .in_valid(in_valid), .in_ready(in_ready), .din(din),
      .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
      .out_err(out_err), .err_clr(err_clr), .err_cnt(err_cnt)
`ifdef SEG7_EN
      , .seg(seg)
`endif
   );

   bcd_decoder4_10 #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .mode_sel(mode_sel),
      .in_valid(in_valid), .in_ready(in_ready2), .din(din),
      .out_valid(out_valid2), .out_ready(out_ready), .dout(dout2),
      .out_err(out_err2), .err_clr(err_clr), .err_cnt(err_cnt2)
`ifdef SEG7_EN
      , .seg(seg2)
`endif
   );

   typedef struct packed {
      logic [9:0] code;
      logic       err;
      logic [6:0] s;
   } word_t;

   localparam logic [6:0] SEGTAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   word_t q[$];
   int    mcnt = 0;
   int    mcnt2 = 0;

   function automatic word_t model(input int d, input bit pri);
      word_t w;
      if (d > 9) begin
         w.code = 10'd0;
         w.err  = 1'b1;
         w.s    = 7'd0;
      end else begin
         w.code = pri ? 10'((1 << (d + 1)) - 1) : 10'(1 << d);
         w.err  = 1'b0;
         w.s    = SEGTAB[d];
      end
      return w;
   endfunction

   task automatic chk(input string n, input logic [31:0] got,
                      input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
      end
   endtask

   // Compare DUT against model, then advance the model with this cycle's inputs
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         mcnt  = 0;
         mcnt2 = 0;
      end else begin
         bit acc, pop, inv;
         chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
         chk("out_valid2", 32'(out_valid2), 32'(q.size() > 0));
         chk("in_ready", 32'(in_ready), 32'(en && q.size() < 2));
         chk("in_ready2", 32'(in_ready2), 32'(en && q.size() < 2));
         if (q.size() > 0) begin
            chk("dout", 32'(dout), 32'(q[0].code));
            chk("dout2", 32'(dout2), 32'(q[0].code));
            chk("out_err", 32'(out_err), 32'(q[0].err));
`ifdef SEG7_EN
            chk("seg", 32'(seg), 32'(q[0].s));
`endif
         end
         chk("err_cnt", 32'(err_cnt), 32'(mcnt));
         chk("err_cnt2", 32'(err_cnt2), 32'(mcnt2));
         acc = in_valid && en && (q.size() < 2);
         pop = out_ready && (q.size() > 0);
         inv = acc && (din > 4'd9);
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(model(int'(din), mode_sel));
         if (err_clr) begin
            mcnt  = inv ? 1 : 0;
            mcnt2 = inv ? 1 : 0;
         end else if (inv) begin
            if (mcnt < 255) mcnt++;
            if (mcnt2 < 3) mcnt2++;
         end
      end
   end

   task automatic step(input bit v, input int d, input bit m,
                       input bit ordy, input bit e, input bit clr);
      @(posedge clk);
      #1;
      in_valid  = v;
      din       = 4'(d);
      mode_sel  = m;
      out_ready = ordy;
      en        = e;
      err_clr   = clr;
   endtask

   localparam logic [9:0] ONEHOT [10] = '{10'h001, 10'h002, 10'h004,
      10'h008, 10'h010, 10'h020, 10'h040, 10'h080, 10'h100, 10'h200};

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      rst = 1'b0;

      for (int i = 0; i <= 10; i++) begin
         step(i < 10, i, 0, 1, 1, 0);
         @(negedge clk);
         if (i > 0) chk("onehot_seq", 32'(dout), 32'(ONEHOT[i-1]));
      end

      step(1, 3, 1, 1, 1, 0);
      @(negedge clk);
      step(1, 9, 1, 1, 1, 0);
      @(negedge clk);
      chk("thermo_3", 32'(dout), 32'h00F);
      step(1, 0, 1, 1, 1, 0);
      @(negedge clk);
      chk("thermo_9", 32'(dout), 32'h3FF);
      step(0, 0, 0, 1, 1, 0);
      @(negedge clk);
      chk("thermo_0", 32'(dout), 32'h001);

      step(1, 12, 0, 1, 1, 0);
      @(negedge clk);
      step(1, 15, 0, 1, 1, 0);
      @(negedge clk);
      chk("inv12_dout", 32'(dout), 32'd0);
      chk("inv12_err", 32'(out_err), 32'd1);
      chk("inv12_cnt", 32'(err_cnt), 32'd1);
      step(1, 10, 0, 1, 1, 1);
      @(negedge clk);
      chk("inv15_err", 32'(out_err), 32'd1);
      chk("inv15_cnt", 32'(err_cnt), 32'd2);
      step(0, 0, 0, 1, 1, 0);
      @(negedge clk);
      chk("clr_inv_cnt", 32'(err_cnt), 32'd1);

      step(1, 5, 0, 0, 1, 0);
      @(negedge clk);
      step(1, 6, 0, 0, 1, 0);
      @(negedge clk);
      chk("bp_ready_one", 32'(in_ready), 32'd1);
      step(1, 7, 0, 0, 1, 0);
      @(negedge clk);
      chk("bp_ready_two", 32'(in_ready), 32'd0);
      chk("bp_hold", 32'(dout), 32'h020);
      step(0, 0, 0, 1, 1, 0);
      @(negedge clk);
      chk("bp_first", 32'(dout), 32'h020);
      step(0, 0, 0, 1, 1, 0);
      @(negedge clk);
      chk("bp_second", 32'(dout), 32'h040);
      chk("bp_ready_back", 32'(in_ready), 32'd1);
      step(0, 0, 0, 1, 1, 0);
      @(negedge clk);
      chk("bp_drained", 32'(out_valid), 32'd0);

      step(0, 0, 0, 1, 1, 1);
      for (int i = 0; i < 5; i++) step(1, 10 + i, 0, 1, 1, 0);
      step(0, 0, 0, 1, 1, 0);
      @(negedge clk);
      chk("sat_cnt2", 32'(err_cnt2), 32'd3);
      chk("sat_cnt8", 32'(err_cnt), 32'd5);

      step(1, 4, 0, 0, 1, 0);
      @(negedge clk);
      step(1, 2, 0, 1, 0, 0);
      @(negedge clk);
      chk("en0_ready", 32'(in_ready), 32'd0);
      chk("en0_dout", 32'(dout), 32'h010);
      step(0, 0, 0, 1, 0, 0);
      @(negedge clk);
      chk("en0_drained", 32'(out_valid), 32'd0);

`ifdef SEG7_EN
      step(1, 8, 0, 1, 1, 0);
      @(negedge clk);
      step(1, 11, 0, 1, 1, 0);
      @(negedge clk);
      chk("seg_8", 32'(seg), 32'h7F);
      step(0, 0, 0, 1, 1, 0);
      @(negedge clk);
      chk("seg_inv", 32'(seg), 32'h00);
`endif

      step(1, 13, 0, 0, 1, 0);
      step(1, 2, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_cnt", 32'(err_cnt), 32'd0);
      chk("midrst_cnt2", 32'(err_cnt2), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      repeat (3000) begin
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
      end
      repeat (4) step(0, 0, 0, 1, 1, 0);
      @(negedge clk);
      chk("final_empty", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
